// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake and payload bundle for pipe_stage_skid_reg; o_stall_cnt exists only
// when PIPE_STAGE_STALL_CNT_EN is defined.
interface pipe_stage_skid_reg_if #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
);
    logic              i_valid;
    logic              o_ready;
    logic [CTRL_W-1:0] i_ctrl;
    logic [DATA_W-1:0] i_data;
    logic              i_flush;
    logic              o_valid;
    logic              i_ready;
    logic [CTRL_W-1:0] o_ctrl;
    logic [DATA_W-1:0] o_data;
    logic [1:0]        o_occupancy;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0]  o_stall_cnt;
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
`endif

    // master: the surrounding pipeline (upstream + downstream); slave: the stage.
`ifdef PIPE_STAGE_STALL_CNT_EN
    modport master (
        output i_valid, i_ctrl, i_data, i_flush, i_ready,
        input  o_ready, o_valid, o_ctrl, o_data, o_occupancy, o_stall_cnt
    );
    modport slave (
        input  i_valid, i_ctrl, i_data, i_flush, i_ready,
        output o_ready, o_valid, o_ctrl, o_data, o_occupancy, o_stall_cnt
    );
`else
    modport master (
        output i_valid, i_ctrl, i_data, i_flush, i_ready,
        input  o_ready, o_valid, o_ctrl, o_data, o_occupancy
    );
    modport slave (
        input  i_valid, i_ctrl, i_data, i_flush, i_ready,
        output o_ready, o_valid, o_ctrl, o_data, o_occupancy
    );
`endif
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Two-entry (main + skid) pipeline register with registered ready and flush.
// Optional stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_skid_reg #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_stage_skid_reg_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic              main_valid;
    logic              ready;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic xfer;

    assign accept = bus.i_valid && ready;
    assign xfer   = main_valid && bus.i_ready;

    // Control fields are zeroed whenever their entry is vacated, so o_ctrl needs no output gating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            ready      <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (bus.i_flush) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            ready      <= 1'b1;
            main_ctrl  <= '0;
            skid_ctrl  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    ready <= 1'b1;
                    if (accept) begin
                        main_valid <= 1'b1;
                        main_ctrl  <= bus.i_ctrl;
                        main_data  <= bus.i_data;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    ready <= 1'b1;
                    if (accept && xfer) begin
                        main_ctrl <= bus.i_ctrl;
                        main_data <= bus.i_data;
                    end else if (accept) begin
                        skid_ctrl <= bus.i_ctrl;
                        skid_data <= bus.i_data;
                        ready     <= 1'b0;
                        state     <= TWO;
                    end else if (xfer) begin
                        main_valid <= 1'b0;
                        main_ctrl  <= '0;
                        state      <= EMPTY;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        skid_ctrl <= '0;
                        ready     <= 1'b1;
                        state     <= ONE;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                    skid_ctrl  <= '0;
                    ready      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = main_valid;
    assign bus.o_ctrl      = main_ctrl;
    assign bus.o_data      = main_data;
    assign bus.o_occupancy = 2'(state);

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (main_valid && !bus.i_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.o_stall_cnt = stall_cnt;
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
`endif

    a_ctrl_gated: assert property (@(posedge clk) disable iff (reset)
        !main_valid |-> main_ctrl == '0);
    a_full_not_ready: assert property (@(posedge clk) disable iff (reset)
        state == TWO |-> !ready);
    a_valid_tracks_state: assert property (@(posedge clk) disable iff (reset)
        main_valid == (state != EMPTY));
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed self-checking bench for pipe_stage_skid_reg: streaming, skid fill/drain,
// flush, asynchronous reset, stall counter (when enabled) and an ordering scoreboard.
module tb_pipe_stage_skid_reg;
    localparam int unsigned CTRL_W = 8;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned CNT_W  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    pipe_stage_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                         input logic [DATA_W-1:0] d, input logic r);
        bus.i_valid = v;
        bus.i_ctrl  = c;
        bus.i_data  = d;
        bus.i_ready = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CTRL_W-1:0] cq[$];
        logic [DATA_W-1:0] dq[$];
        logic [15:0]       vpat;
        logic [15:0]       rpat;
        logic [CTRL_W-1:0] ec;
        logic [DATA_W-1:0] ed;

        bus.i_flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);

        // reset state
        #2;
        check("rst_valid", bus.o_valid, 0);
        check("rst_ctrl", bus.o_ctrl, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_occ", bus.o_occupancy, 0);
        check("rst_ready", bus.o_ready, 0);
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("rst_cnt", bus.o_stall_cnt, 0);
`endif
        step();
        step();
        reset = 1'b0;
        step();
        check("ready_after_rst", bus.o_ready, 1);

        // back-to-back streaming
        drive(1'b1, 8'h81, 'h11, 1'b1);
        step();
        check("s1_valid", bus.o_valid, 1);
        check("s1_data", bus.o_data, 'h11);
        check("s1_ctrl", bus.o_ctrl, 'h81);
        check("s1_occ", bus.o_occupancy, 1);
        check("s1_ready", bus.o_ready, 1);
        drive(1'b1, 8'h82, 'h22, 1'b1);
        step();
        check("s2_data", bus.o_data, 'h22);
        check("s2_ready", bus.o_ready, 1);
        drive(1'b1, 8'h83, 'h33, 1'b1);
        step();
        check("s3_data", bus.o_data, 'h33);
        check("s3_occ", bus.o_occupancy, 1);
        drive(1'b0, '0, '0, 1'b1);
        step();
        check("s4_valid", bus.o_valid, 0);
        check("s4_ctrl", bus.o_ctrl, 0);
        check("s4_data_kept", bus.o_data, 'h33);
        check("s4_occ", bus.o_occupancy, 0);

        // skid fill and drain
        drive(1'b1, 8'h0A, 'hA, 1'b0);
        step();
        check("k1_occ", bus.o_occupancy, 1);
        check("k1_data", bus.o_data, 'hA);
        drive(1'b1, 8'h0B, 'hB, 1'b0);
        step();
        check("k2_occ", bus.o_occupancy, 2);
        check("k2_ready", bus.o_ready, 0);
        check("k2_data", bus.o_data, 'hA);
        drive(1'b0, '0, '0, 1'b0);
        step();
        check("k3_data_stable", bus.o_data, 'hA);
        check("k3_ctrl_stable", bus.o_ctrl, 'h0A);
        check("k3_occ", bus.o_occupancy, 2);
        drive(1'b0, '0, '0, 1'b1);
        step();
        check("k4_data", bus.o_data, 'hB);
        check("k4_ctrl", bus.o_ctrl, 'h0B);
        check("k4_occ", bus.o_occupancy, 1);
        check("k4_ready", bus.o_ready, 1);
        step();
        check("k5_valid", bus.o_valid, 0);
        check("k5_occ", bus.o_occupancy, 0);
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("k5_cnt", bus.o_stall_cnt, 2);
`endif

        // flush beats simultaneous accept and transfer
        drive(1'b1, 8'h01, 'h1, 1'b0);
        step();
        drive(1'b1, 8'h02, 'h2, 1'b0);
        step();
        check("f1_occ", bus.o_occupancy, 2);
        bus.i_flush = 1'b1;
        drive(1'b1, 8'hCC, 'hC, 1'b1);
        step();
        check("f2_valid", bus.o_valid, 0);
        check("f2_ctrl", bus.o_ctrl, 0);
        check("f2_occ", bus.o_occupancy, 0);
        check("f2_ready", bus.o_ready, 1);
        bus.i_flush = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        step();
        check("f3_valid", bus.o_valid, 0);
        check("f3_data_not_c", bus.o_data, 'h1);
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("f3_cnt", bus.o_stall_cnt, 3);
`endif

        // asynchronous reset with two entries held
        drive(1'b1, 8'h05, 'h5, 1'b0);
        step();
        drive(1'b1, 8'h06, 'h6, 1'b0);
        step();
        check("r1_occ", bus.o_occupancy, 2);
        drive(1'b0, '0, '0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("r2_valid", bus.o_valid, 0);
        check("r2_ctrl", bus.o_ctrl, 0);
        check("r2_occ", bus.o_occupancy, 0);
        check("r2_ready", bus.o_ready, 0);
        step();
        reset = 1'b0;
        step();
        check("r3_ready", bus.o_ready, 1);
        check("r3_occ", bus.o_occupancy, 0);
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("r3_cnt", bus.o_stall_cnt, 0);

        // stall counter saturation
        drive(1'b1, 8'h07, 'h7, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        repeat (20) step();
        check("c_sat", bus.o_stall_cnt, 15);
        check("c_data", bus.o_data, 'h7);
        drive(1'b0, '0, '0, 1'b1);
        step();
        check("c_drain", bus.o_valid, 0);
        check("c_hold", bus.o_stall_cnt, 15);
`endif

        // ordering under mixed valid/ready patterns
        vpat = 16'b1011_1110_1101_1111;
        rpat = 16'b1100_1011_0110_1001;
        for (int i = 0; i < 16; i++) begin
            drive(vpat[i], CTRL_W'(8'h40 + i), DATA_W'(32'hD000 + i), rpat[i]);
            if (bus.o_valid && bus.i_ready) begin
                if (dq.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    ec = cq.pop_front();
                    ed = dq.pop_front();
                    check("sb_data", bus.o_data, ed);
                    check("sb_ctrl", bus.o_ctrl, DATA_W'(ec));
                end
            end
            if (bus.i_valid && bus.o_ready) begin
                cq.push_back(bus.i_ctrl);
                dq.push_back(bus.i_data);
            end
            step();
        end
        drive(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (bus.o_valid) begin
                if (dq.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    ec = cq.pop_front();
                    ed = dq.pop_front();
                    check("sb_data", bus.o_data, ed);
                    check("sb_ctrl", bus.o_ctrl, DATA_W'(ec));
                end
            end
            step();
        end
        check("sb_empty", DATA_W'(dq.size()), 0);
        check("sb_idle", bus.o_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid_reg.md
PIPE_STAGE_SKID_REG -- requirements
Module: pipe_stage_skid_reg

Interface
REQ-001 Parameter CTRL_W, default 8, SHALL set the control field width (reg_write, mem_read, mem_write, mem_to_reg, ...).
REQ-002 Parameter DATA_W, default 128, SHALL set the payload width (pc_4, data_2, imm_ext, register indices, ...).
REQ-003 Parameter CNT_W, default 16, SHALL set the stall counter width.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 i_valid  input  1  upstream entry present.
REQ-007 o_ready  output  1  stage can accept; a transfer occurs when i_valid && o_ready.
REQ-008 i_ctrl  input  CTRL_W  upstream control field.
REQ-009 i_data  input  DATA_W  upstream payload.
REQ-010 i_flush  input  1  synchronous kill of all held entries.
REQ-011 o_valid  output  1  downstream entry present.
REQ-012 i_ready  input  1  downstream accepts; a transfer occurs when o_valid && i_ready.
REQ-013 o_ctrl  output  CTRL_W  control field of the head entry, all-zero when o_valid=0.
REQ-014 o_data  output  DATA_W  payload of the head entry.
REQ-015 o_occupancy  output  2  number of held entries (0..2).
REQ-016 o_stall_cnt  output  CNT_W  stall count; present only with PIPE_STAGE_STALL_CNT_EN.

Function
REQ-017 Storage SHALL be one main entry and one skid entry, each holding {ctrl, data, valid}; states EMPTY (0), ONE (main only), TWO (main+skid).
REQ-018 o_ready SHALL be a registered signal equal to !skid_valid, with no combinational path from i_ready.
REQ-019 Latency SHALL be one cycle: an entry accepted at edge N is on o_valid/o_data after edge N.
REQ-020 EMPTY: accept -> ONE; otherwise remain.
REQ-021 ONE: accept with downstream transfer -> ONE with new entry in main; accept without transfer -> TWO with new entry in skid; transfer without accept -> EMPTY; neither -> hold.
REQ-022 TWO: o_ready=0; downstream transfer -> skid moves to main, state ONE; otherwise hold all contents unchanged.
REQ-023 Entry order SHALL be preserved; no entry SHALL be duplicated or dropped except by flush.
REQ-024 With i_valid=i_ready=1 continuously, throughput SHALL be one entry per cycle with occupancy 1.
REQ-025 While o_valid=1 && i_ready=0, o_ctrl and o_data SHALL remain stable.
REQ-026 i_flush=1 SHALL clear both valid bits at the next edge, take priority over simultaneous accept and transfer, and drop the same-cycle upstream entry; o_ready SHALL be 1 the following cycle.
REQ-027 o_ctrl SHALL be gated to zero whenever o_valid=0 so a bubble never asserts write enables.
REQ-028 o_data of a non-valid stage is don't-care but SHALL retain its last value (no toggling on bubbles).

Reset
REQ-029 During reset: o_valid=0, o_ctrl=0, o_data=0, o_occupancy=0, o_ready=0, skid cleared, o_stall_cnt=0.
REQ-030 o_ready SHALL rise to 1 at the first edge after reset deasserts.
REQ-031 Reset asserted mid-transfer SHALL discard all entries immediately, independent of clk.

Configuration
REQ-032 With PIPE_STAGE_STALL_CNT_EN defined, o_stall_cnt SHALL increment by 1 each cycle o_valid=1 && i_ready=0, saturate at 2^CNT_W-1, and clear only on reset.
REQ-033 Without PIPE_STAGE_STALL_CNT_EN, the port and counter SHALL not exist; all other behaviour is identical.

Verification
REQ-034 Reset, then i_valid=1, data 0x11,0x22,0x33 on consecutive cycles, i_ready=1 -> o_data 0x11,0x22,0x33 one cycle later each, occupancy 1, o_ready stays 1.
REQ-035 Hold i_ready=0, send 0xA then 0xB -> occupancy 2, o_ready=0, o_data=0xA stable; raise i_ready -> 0xA then 0xB out in order, o_ready=1 after the first transfer.
REQ-036 Occupancy 2 with i_flush=1 and i_valid=1 data 0xC -> next cycle o_valid=0, o_ctrl=0, occupancy 0, 0xC never appears.
REQ-037 Assert reset asynchronously between edges with occupancy 2 -> o_valid=0 and o_ctrl=0 immediately; after release, o_ready=1 at the first edge.
REQ-038 With PIPE_STAGE_STALL_CNT_EN, CNT_W=4, o_valid=1 and i_ready=0 for 20 cycles -> o_stall_cnt reaches 15 and holds.
